width_narrow: RTL and testbench
===============================

WIDTH_NARROW -- requirements
Module: width_narrow

Interface
REQ-001 SHALL provide parameter IN_W, default 6, width of each accepted input word (>=1).
REQ-002 SHALL provide parameter OUT_W, default 2, width of each emitted output beat (>=1).
REQ-003 SHALL define derived constant BEATS = ceil(IN_W/OUT_W), beats per word; PAD_W = BEATS*OUT_W.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data holds a word to accept.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  IN_W  wide word to narrow.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts beat this cycle.
REQ-011 out_data  output  OUT_W  current narrow beat.
REQ-012 out_last  output  1  asserted with final beat of a word.

Function
REQ-013 SHALL accept a word on any rising edge where in_valid && in_ready, zero-extending it at the MSB end to PAD_W bits in an internal holding register.
REQ-014 SHALL implement two states: IDLE (no word held) and SEND (word held, beats pending).
REQ-015 IDLE: out_valid=0, in_ready=1; on input handshake -> SEND with beat counter=0.
REQ-016 SEND: out_valid=1; beat index k emits PAD_W bits [k*OUT_W +: OUT_W] (LSB-first default).
REQ-017 SHALL advance beat counter only on out_valid && out_ready; out_data and out_last SHALL stay stable while out_ready=0.
REQ-018 out_last SHALL be 1 exactly when beat counter = BEATS-1 in SEND.
REQ-019 in_ready SHALL be 1 in IDLE, and in SEND only when out_last && out_ready (combinational back-to-back path); otherwise 0.
REQ-020 Last-beat handshake with simultaneous input handshake: load new word, counter=0, remain SEND, no idle bubble.
REQ-021 Last-beat handshake without input handshake: -> IDLE.
REQ-022 IN_W <= OUT_W: BEATS=1, each word emitted as one beat, upper OUT_W-IN_W bits zero.
REQ-023 IN_W not a multiple of OUT_W: final beat upper bits zero-padded; no input bit dropped or duplicated.
REQ-024 First beat SHALL be available the cycle after acceptance (latency 1); one word occupies BEATS cycles under continuous out_ready.
REQ-025 Beat counter width SHALL be max(1,$clog2(BEATS)); counter SHALL never exceed BEATS-1.

Reset
REQ-026 On rst_n=0, immediately (asynchronously): state=IDLE, counter=0, holding register=0, out_valid=0, out_last=0, out_data=0.
REQ-027 in_ready SHALL read 0 while rst_n=0 and 1 in the first cycle after release.
REQ-028 Reset mid-word SHALL discard remaining beats; no beat of that word reappears after release.

Configuration
REQ-029 Macro WIDTH_NARROW_MSB_FIRST_EN defined: beat k emits PAD_W bits [(BEATS-1-k)*OUT_W +: OUT_W] (zero padding therefore appears in first beat).
REQ-030 Macro undefined: LSB-first ordering per REQ-016; all other behaviour identical in both builds.

Verification
REQ-031 IN_W=6, OUT_W=2, in_data=6'b110110, out_ready=1 -> out_data 2'b10, 2'b01, 2'b11 on consecutive cycles, out_last on third only.
REQ-032 IN_W=5, OUT_W=2, in_data=5'b10111 -> beats 2'b11, 2'b01, 2'b01; MSB_FIRST build -> 2'b01, 2'b01, 2'b11.
REQ-033 IN_W=1, OUT_W=2, in_data=1'b1 then 1'b0 -> single beats 2'b01 then 2'b00, each with out_last=1.
REQ-034 IN_W=6, OUT_W=2, out_ready low 3 cycles at beat 1 -> out_data 2'b01 held stable, in_ready=0, resumes with 2'b11.
REQ-035 Words 6'h36 and 6'h0F offered back-to-back, out_ready=1 -> 6 beats in 6 consecutive cycles (10,01,11,11,11,00), in_ready=1 on cycle of first word's last beat.
REQ-036 rst_n pulsed low during beat 1 of 6'h36 -> out_valid=0 immediately; after release in_ready=1, next word's first beat is its own beat 0.

Source files
------------

// File: rtl/width_narrow.sv
// Wide-to-narrow stream adapter: holds one IN_W word and emits it as BEATS beats of OUT_W bits.
// Define WIDTH_NARROW_MSB_FIRST_EN to emit the most significant beat first (default is LSB-first).
module width_narrow #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_out_last
);

  localparam int BEATS = (IN_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W = BEATS * OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PAD_W-1:0]   r_hold;
  logic [PAD_W-1:0]   w_hold_nxt;
  logic               w_last;
  logic               w_in_hs;
  logic               w_out_hs;
  int                 w_beat;

  assign w_last      = (r_state == SEND) && (r_cnt == LAST_CNT);
  assign o_out_valid = (r_state == SEND);
  assign o_out_last  = w_last;
  // Ready is forced low during reset so nothing is offered as accepted while the block is held.
  assign o_in_ready  = rst_n && ((r_state == IDLE) || (w_last && i_out_ready));
  assign w_in_hs     = i_in_valid && o_in_ready;
  assign w_out_hs    = o_out_valid && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_in_hs) begin
          w_state_nxt = SEND;
          w_cnt_nxt   = '0;
          w_hold_nxt  = PAD_W'(i_in_data);
        end
      end
      SEND: begin
        if (w_out_hs) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (w_in_hs) begin
              w_hold_nxt = PAD_W'(i_in_data);
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
`ifdef WIDTH_NARROW_MSB_FIRST_EN
    w_beat = (BEATS - 1) - int'(r_cnt);
`else
    w_beat = int'(r_cnt);
`endif
    o_out_data = '0;
    if (r_state == SEND) begin
      o_out_data = r_hold[w_beat*OUT_W +: OUT_W];
    end
  end

endmodule

// File: tb/tb_width_narrow.sv
// Bench for width_narrow: directed scenarios plus random traffic scored against a beat-queue model.
module tb_width_narrow;

  localparam int IN_W  = 6;
  localparam int OUT_W = 2;
  localparam int BEATS = (IN_W + OUT_W - 1) / OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  logic       v5, ir5, r5, ov5, ol5;
  logic [4:0] d5;
  logic [1:0] od5;
  logic       v1, ir1, r1, ov1, ol1;
  logic [0:0] d1;
  logic [1:0] od1;

  int checks = 0;
  int errors = 0;

  beat_t            q[$];
  logic             obs_ov, obs_ir, obs_last;
  logic [OUT_W-1:0] obs_data;

  always #5 clk = ~clk;

  width_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_last(out_last)
  );

  width_narrow #(.IN_W(5), .OUT_W(2)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(v5), .o_in_ready(ir5), .i_in_data(d5),
    .o_out_valid(ov5), .i_out_ready(r5),
    .o_out_data(od5), .o_out_last(ol5)
  );

  width_narrow #(.IN_W(1), .OUT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(v1), .o_in_ready(ir1), .i_in_data(d1),
    .o_out_valid(ov1), .i_out_ready(r1),
    .o_out_data(od1), .o_out_last(ol1)
  );

`ifdef WIDTH_NARROW_MSB_FIRST_EN
  localparam logic [5:0] E36 = 6'b11_01_10;
  localparam logic [5:0] E0F = 6'b00_11_11;
  localparam logic [5:0] E5  = 6'b01_01_11;
`else
  localparam logic [5:0] E36 = 6'b10_01_11;
  localparam logic [5:0] E0F = 6'b11_11_00;
  localparam logic [5:0] E5  = 6'b11_01_01;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat k of a word: arithmetic slice of the zero-extended value, ordering chosen by build.
  function automatic logic [OUT_W-1:0] beat_of(input logic [IN_W-1:0] w, input int k);
    longint unsigned wl;
    int idx;
    wl = longint'(w);
`ifdef WIDTH_NARROW_MSB_FIRST_EN
    idx = BEATS - 1 - k;
`else
    idx = k;
`endif
    return OUT_W'((wl >> (idx * OUT_W)) & ((64'd1 << OUT_W) - 1));
  endfunction

  // One clock cycle: drive, check against the queue model, then advance the model at the edge.
  task automatic step(input logic v, input logic [IN_W-1:0] d, input logic r);
    logic  exp_ov, exp_ir;
    beat_t b;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    exp_ov = (q.size() != 0);
    exp_ir = (q.size() == 0) || (q.size() == 1 && r);
    obs_ov = out_valid; obs_ir = in_ready; obs_data = out_data; obs_last = out_last;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (exp_ov) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_last", 32'(out_last), 32'(q[0].l));
    end
    @(posedge clk);
    if (exp_ov && r) void'(q.pop_front());
    if (v && exp_ir) begin
      for (int k = 0; k < BEATS; k++) begin
        b.d = beat_of(d, k);
        b.l = (k == BEATS - 1);
        q.push_back(b);
      end
    end
    #1;
  endtask

  initial begin
    logic [5:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    v5 = 1'b0; d5 = '0; r5 = 1'b1;
    v1 = 1'b0; d1 = '0; r1 = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word, continuous ready.
    step(1'b1, 6'b110110, 1'b1);
    e = E36;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      chk("w36_data", 32'(obs_data), 32'(e[5-2*k -: 2]));
      chk("w36_last", 32'(obs_last), 32'(k == 2));
    end
    step(1'b0, '0, 1'b1);
    chk("w36_idle", 32'(obs_ov), 32'd0);

    // Back-to-back words: second accepted on the first word's last beat.
    step(1'b1, 6'h36, 1'b1);
    step(1'b1, 6'h0F, 1'b1);
    step(1'b1, 6'h0F, 1'b1);
    step(1'b1, 6'h0F, 1'b1);
    chk("b2b_ready_on_last", 32'(obs_ir), 32'd1);
    e = E0F;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 1'b1);
      chk("b2b_w2_data", 32'(obs_data), 32'(e[5-2*k -: 2]));
    end
    step(1'b0, '0, 1'b1);

    // Backpressure at beat 1, with a competing word offered during the stall.
    step(1'b1, 6'h36, 1'b1);
    step(1'b0, '0, 1'b1);
    e = E36;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 6'h2A, 1'b0);
      chk("stall_data", 32'(obs_data), 32'(e[3:2]));
      chk("stall_ready", 32'(obs_ir), 32'd0);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("stall_resume", 32'(obs_data), 32'(e[1:0]));
    step(1'b0, '0, 1'b1);

    // Reset during beat 1: beats discarded, next word starts at its own beat 0.
    step(1'b1, 6'h36, 1'b1);
    step(1'b0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 6'h0F, 1'b1);
    chk("postrst_in_ready", 32'(obs_ir), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("postrst_beat0", 32'(obs_data), 32'(E0F[5:4]));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), IN_W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // IN_W=5 / OUT_W=2: padding lands in the top bit of the word's highest beat.
    v5 = 1'b1; d5 = 5'b10111;
    @(posedge clk); #1;
    v5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("w5_data", 32'(od5), 32'(E5[5-2*k -: 2]));
      chk("w5_last", 32'(ol5), 32'(k == 2));
      @(posedge clk); #1;
    end
    chk("w5_idle", 32'(ov5), 32'd0);

    // IN_W=1 / OUT_W=2: one beat per word, back-to-back.
    v1 = 1'b1; d1 = 1'b1;
    @(posedge clk); #1;
    d1 = 1'b0;
    chk("w1_a_data", 32'(od1), 32'h1);
    chk("w1_a_last", 32'(ol1), 32'd1);
    chk("w1_a_ready", 32'(ir1), 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("w1_b_data", 32'(od1), 32'h0);
    chk("w1_b_valid", 32'(ov1), 32'd1);
    chk("w1_b_last", 32'(ol1), 32'd1);
    @(posedge clk); #1;
    chk("w1_idle", 32'(ov1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
